// File: rtl/adder_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : adder_arbiter_pkg
// Brief    : Shared FSM encoding, counter width and round-robin pick helper.
// Revision : 1.0
// ============================================================================
package adder_arbiter_pkg;

    localparam int OPS_W   = 16;
    localparam int MAX_REQ = 8;
    localparam int IDX_W   = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // First valid lane at or after ptr, scanning upward modulo nreq.
    function automatic logic [IDX_W-1:0] rr_select(
        input logic [MAX_REQ-1:0] valid,
        input logic [IDX_W-1:0]   ptr,
        input int                 nreq
    );
        logic [IDX_W-1:0] pick;
        logic             found;
        int               idx;
        pick  = '0;
        found = 1'b0;
        for (int i = 0; i < MAX_REQ; i++) begin
            idx = (int'(ptr) + i) % nreq;
            if (!found && (i < nreq) && valid[idx[IDX_W-1:0]]) begin
                pick  = idx[IDX_W-1:0];
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage
`default_nettype wire

// File: rtl/adder.sv
`default_nettype none
// ============================================================================
// Module   : adder
// Brief    : Combinational W-bit adder, carry discarded.
// Revision : 1.0
// ============================================================================
module adder #(
    parameter int W = 32
) (
    input  logic [W-1:0] ina,
    input  logic [W-1:0] inb,
    output logic [W-1:0] outx
);

    assign outx = ina + inb;

endmodule
`default_nettype wire

// File: rtl/adder_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : adder_arbiter
// Brief    : Round-robin shared adder; one operation in flight, IDLE/CALC/RESP.
// Revision : 1.0
// ============================================================================
module adder_arbiter
    import adder_arbiter_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int W    = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ*W-1:0] req_a,
    input  logic [NREQ*W-1:0] req_b,
    output logic [NREQ-1:0]   req_ready,
    output logic [NREQ-1:0]   rsp_valid,
    input  logic [NREQ-1:0]   rsp_ready,
    output logic [W-1:0]      rsp_data,
    output logic              busy,
    output logic [OPS_W-1:0]  ops_done
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NREQ - 1);

    state_t               r_state;
    state_t               w_state_nxt;
    logic [IDX_W-1:0]     r_rr_ptr;
    logic [IDX_W-1:0]     r_grant;
    logic [W-1:0]         r_op_a;
    logic [W-1:0]         r_op_b;
    logic [W-1:0]         r_rsp_data;
    logic [OPS_W-1:0]     r_ops_done;

    logic [MAX_REQ-1:0]   w_valid_pad;
    logic [IDX_W-1:0]     w_winner;
    logic [NREQ-1:0]      w_winner_oh;
    logic [NREQ-1:0]      w_grant_oh;
    logic                 w_any_valid;
    logic                 w_accept;
    logic                 w_complete;
    logic [W-1:0]         w_sum;

    always_comb begin
        w_valid_pad             = '0;
        w_valid_pad[NREQ-1:0]   = req_valid;
    end

    assign w_any_valid = |req_valid;
    assign w_winner    = rr_select(w_valid_pad, r_rr_ptr, NREQ);

    for (genvar i = 0; i < NREQ; i++) begin : g_lane
        assign w_winner_oh[i] = (w_winner == IDX_W'(i));
        assign w_grant_oh[i]  = (r_grant  == IDX_W'(i));
    end

    assign w_accept   = (r_state == ST_IDLE) && w_any_valid;
    assign w_complete = (r_state == ST_RESP) && |(rsp_ready & w_grant_oh);

    adder #(
        .W    (W)
    ) u_adder (
        .ina  (r_op_a),
        .inb  (r_op_b),
        .outx (w_sum)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_any_valid) w_state_nxt = ST_CALC;
            ST_CALC: w_state_nxt = ST_RESP;
            ST_RESP: if (w_complete) w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_grant    <= '0;
            r_op_a     <= '0;
            r_op_b     <= '0;
            r_rsp_data <= '0;
            r_rr_ptr   <= '0;
            r_ops_done <= '0;
        end else begin
            if (w_accept) begin
                r_grant <= w_winner;
                r_op_a  <= req_a[int'(w_winner)*W +: W];
                r_op_b  <= req_b[int'(w_winner)*W +: W];
            end
            if (r_state == ST_CALC) begin
                r_rsp_data <= w_sum;
            end
            // Pointer moves only on completion so an accepted-but-unfinished op
            // never shifts fairness.
            if (w_complete) begin
                r_rr_ptr   <= (r_grant == LAST_IDX) ? '0 : r_grant + 1'b1;
                r_ops_done <= r_ops_done + 1'b1;
            end
        end
    end

    // Gate with reset so a held request is never acknowledged while in reset.
    assign req_ready = (reset && w_accept) ? w_winner_oh : '0;
    assign rsp_valid = (r_state == ST_RESP) ? w_grant_oh : '0;
    assign rsp_data  = r_rsp_data;
    assign busy      = (r_state != ST_IDLE);
    assign ops_done  = r_ops_done;

    a_req_ready_onehot : assert property (@(posedge clk) disable iff (!reset)
        $onehot0(req_ready));
    a_rsp_valid_onehot : assert property (@(posedge clk) disable iff (!reset)
        $onehot0(rsp_valid));

endmodule
`default_nettype wire

// File: doc/adder_arbiter.md
ADDER_ARBITER -- requirements
Module: adder_arbiter

Interface
REQ-001 Parameter NREQ, default 4, number of requesters (2..8).
REQ-002 Parameter W, default 32, operand/result width.
REQ-003 clk  input  1  sole clock, all state on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-005 req_valid  input  NREQ  per-requester operand-valid.
REQ-006 req_a  input  NREQ*W  packed operand A, requester i at bits [i*W +: W].
REQ-007 req_b  input  NREQ*W  packed operand B, same packing.
REQ-008 req_ready  output  NREQ  per-requester accept; one-hot or zero.
REQ-009 rsp_valid  output  NREQ  per-requester result-valid; one-hot or zero.
REQ-010 rsp_ready  input  NREQ  per-requester result-accept.
REQ-011 rsp_data  output  W  sum, shared by all requesters, qualified by rsp_valid.
REQ-012 busy  output  1  high in any state other than IDLE.
REQ-013 ops_done  output  16  count of completed responses; wraps 0xFFFF -> 0.

Function
REQ-014 FSM states IDLE, CALC, RESP; encoding in package.
REQ-015 IDLE: if any req_valid, select winner by round-robin starting at rr_ptr and ascending modulo NREQ; req_ready[winner]=1 combinationally in that cycle; latch req_a/req_b of winner and grant index; go to CALC.
REQ-016 IDLE with no req_valid: req_ready all 0, stay IDLE.
REQ-017 req_ready is 0 in CALC and RESP; requests presented then stay pending (valid must be held by requester).
REQ-018 CALC: register adder output (latched A + latched B, modulo 2^W, carry discarded) into rsp_data; go to RESP.
REQ-019 RESP: rsp_valid[grant]=1, rsp_data stable; when rsp_ready[grant]=1 go to IDLE, set rr_ptr = (grant+1) mod NREQ, increment ops_done.
REQ-020 rsp_ready of non-granted requesters is ignored.
REQ-021 Latency: accept at edge T -> rsp_valid high from cycle T+2; back-to-back throughput one op per 3 cycles with rsp_ready held high.
REQ-022 Requester that drops req_valid without handshake is not served; no state change.
REQ-023 rr_ptr advances only on response completion, never on accept.
REQ-024 Pending requester is served within NREQ completed operations (starvation-free).

Reset
REQ-025 reset low asynchronously forces: state IDLE, rr_ptr 0, ops_done 0, rsp_data 0, latched operands 0, grant 0.
REQ-026 During reset: req_ready 0, rsp_valid 0, busy 0.
REQ-027 Reset mid-operation (CALC or RESP) abandons the operation; no response is produced after release, ops_done not incremented.
REQ-028 First arbitration after release starts at requester 0.

Structure
REQ-029 Package adder_arbiter_pkg holds FSM state typedef and ops_done width constant.
REQ-030 Sum computed by one instance of existing sub-module adder (ina, inb, outx); no other arithmetic on operands.
REQ-031 Round-robin selection as a function in the package or inline; no second sub-module.

Verification
REQ-032 Single request: req0 a=5 b=2 after reset -> req_ready[0] same cycle, rsp_valid[0] two cycles later, rsp_data=7, ops_done=1.
REQ-033 All four valid continuously, rsp_ready all 1 -> grant order 0,1,2,3,0; each rsp_data correct; one op per 3 cycles.
REQ-034 Wrap: a=0xFFFFFFFF b=1 -> rsp_data=0; a=0x80000000 b=0x80000000 -> rsp_data=0.
REQ-035 Backpressure: rsp_ready[1] low 5 cycles in RESP -> rsp_valid[1] and rsp_data held, req_ready all 0, other requesters wait.
REQ-036 Reset asserted in RESP -> outputs zero immediately; after release no stale rsp_valid, next grant to requester 0.
REQ-037 ops_done preset by 65536 completions -> reads 0; rsp_ready on non-granted lanes never completes an op.
